// File: rtl/urom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : urom_loader
//  Description : Host-stream loader for the six-lane microcode RAM. Holds the
//                micro-sequencer in reset while the image is written, then
//                releases it. Optional trailing XOR checksum is enabled by
//                defining UROM_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module urom_loader #(
    parameter int ADDR_WIDTH = 13,
    parameter int WORD_BYTES = 6,
    parameter int WE_CYCLES  = 2
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [7:0]            rom_data,
    output logic [WORD_BYTES-1:0] rom_notWE,
    output logic                  rom_notOE,
    output logic                  seq_notReset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int c_lane_w = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_we_w   = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [c_lane_w-1:0]   c_last_lane = c_lane_w'(WORD_BYTES - 1);
    localparam logic [c_we_w-1:0]     c_last_we   = c_we_w'(WE_CYCLES - 1);
    localparam logic [16:0]           c_depth     = 17'(1) << ADDR_WIDTH;
    localparam logic [WORD_BYTES-1:0] c_we_idle   = '1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HDR_LO    = 4'd1,
        S_HDR_HI    = 4'd2,
        S_DATA_WAIT = 4'd3,
        S_WR_SETUP  = 4'd4,
        S_WR_PULSE  = 4'd5,
        S_WR_HOLD   = 4'd6,
`ifdef UROM_LOADER_CHECKSUM_EN
        S_CKSUM     = 4'd7,
`endif
        S_DONE      = 4'd8,
        S_ERROR     = 4'd9
    } state_t;

    state_t              r_state;
    logic [c_lane_w-1:0] r_lane;
    logic [15:0]         r_count;
    logic [c_we_w-1:0]   r_we_cnt;

    logic                  w_idle_like;
    logic                  w_take;
    logic [15:0]           w_hdr_n;
    logic                  w_hdr_bad;
    logic                  w_last_byte;
    logic [WORD_BYTES-1:0] w_strobe;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_take      = in_valid & in_ready;
    assign w_hdr_n     = {in_data, r_count[7:0]};
    assign w_hdr_bad   = (w_hdr_n == 16'd0) || ({1'b0, w_hdr_n} > c_depth);
    // Last byte of the image: final lane of word N-1; rom_addr is never advanced past it.
    assign w_last_byte = (r_lane == c_last_lane) &&
                         ((17'(rom_addr) + 17'd1) == {1'b0, r_count});
    assign w_strobe    = ~(WORD_BYTES'(1) << r_lane);

`ifdef UROM_LOADER_CHECKSUM_EN
    logic [7:0] r_cksum;

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_cksum <= '0;
        end else if (w_idle_like && start) begin
            r_cksum <= '0;
        end else if (w_take) begin
            r_cksum <= r_cksum ^ in_data;
        end
    end
`endif

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_state      <= S_IDLE;
            in_ready     <= 1'b0;
            rom_addr     <= '0;
            rom_data     <= '0;
            rom_notWE    <= c_we_idle;
            rom_notOE    <= 1'b0;
            seq_notReset <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            r_lane       <= '0;
            r_count      <= '0;
            r_we_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state      <= S_HDR_LO;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        rom_notOE    <= 1'b1;
                        seq_notReset <= 1'b0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        r_lane       <= '0;
                        rom_addr     <= '0;
                        r_count      <= '0;
                    end
                end

                S_HDR_LO: begin
                    if (w_take) begin
                        r_count[7:0] <= in_data;
                        r_state      <= S_HDR_HI;
                    end
                end

                S_HDR_HI: begin
                    if (w_take) begin
                        if (w_hdr_bad) begin
                            r_state  <= S_ERROR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            r_count[15:8] <= in_data;
                            r_state       <= S_DATA_WAIT;
                        end
                    end
                end

                S_DATA_WAIT: begin
                    if (w_take) begin
                        rom_data <= in_data;
                        in_ready <= 1'b0;
                        r_state  <= S_WR_SETUP;
                    end
                end

                S_WR_SETUP: begin
                    rom_notWE <= w_strobe;
                    r_we_cnt  <= '0;
                    r_state   <= S_WR_PULSE;
                end

                S_WR_PULSE: begin
                    if (r_we_cnt == c_last_we) begin
                        rom_notWE <= c_we_idle;
                        r_state   <= S_WR_HOLD;
                    end else begin
                        r_we_cnt <= r_we_cnt + c_we_w'(1);
                    end
                end

                S_WR_HOLD: begin
                    if (w_last_byte) begin
                        r_lane <= '0;
`ifdef UROM_LOADER_CHECKSUM_EN
                        r_state  <= S_CKSUM;
                        in_ready <= 1'b1;
`else
                        r_state      <= S_DONE;
                        busy         <= 1'b0;
                        rom_notOE    <= 1'b0;
                        seq_notReset <= 1'b1;
                        done         <= 1'b1;
`endif
                    end else begin
                        r_state  <= S_DATA_WAIT;
                        in_ready <= 1'b1;
                        if (r_lane == c_last_lane) begin
                            r_lane   <= '0;
                            rom_addr <= rom_addr + ADDR_WIDTH'(1);
                        end else begin
                            r_lane <= r_lane + c_lane_w'(1);
                        end
                    end
                end

`ifdef UROM_LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    if (w_take) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == r_cksum) begin
                            r_state      <= S_DONE;
                            rom_notOE    <= 1'b0;
                            seq_notReset <= 1'b1;
                            done         <= 1'b1;
                        end else begin
                            // Image stays in RAM but the sequencer is kept in reset.
                            r_state <= S_ERROR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    r_state      <= S_ERROR;
                    in_ready     <= 1'b0;
                    rom_notWE    <= c_we_idle;
                    rom_notOE    <= 1'b1;
                    seq_notReset <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    error        <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_urom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_urom_loader
//  Description : Randomised stream bench for urom_loader with a queue-based
//                model of the expected RAM writes and load outcome.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_urom_loader;

    localparam int ADDR_WIDTH = 13;
    localparam int WORD_BYTES = 6;
    localparam int WE_CYCLES  = 2;

    logic                  clock    = 1'b0;
    logic                  notReset = 1'b1;
    logic                  start    = 1'b0;
    logic [7:0]            in_data  = 8'h00;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [7:0]            rom_data;
    logic [WORD_BYTES-1:0] rom_notWE;
    logic                  rom_notOE;
    logic                  seq_notReset;
    logic                  busy;
    logic                  done;
    logic                  error;

    always #5 clock = ~clock;

    urom_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_BYTES (WORD_BYTES),
        .WE_CYCLES  (WE_CYCLES)
    ) dut (
        .clock        (clock),
        .notReset     (notReset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rom_notWE    (rom_notWE),
        .rom_notOE    (rom_notOE),
        .seq_notReset (seq_notReset),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            lane;
        logic [7:0]            data;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         writes_seen = 0;
    wr_t        exp_q[$];
    logic [7:0] data_q[$];
    logic [7:0] last_ck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_of(input logic [WORD_BYTES-1:0] w);
        for (int i = 0; i < WORD_BYTES; i++)
            if (!w[i]) return i;
        return -1;
    endfunction

    // Per-cycle observer: every strobe must match the head of the expected write queue.
    initial begin
        logic [WORD_BYTES-1:0] prev_we;
        logic [ADDR_WIDTH-1:0] held_addr;
        logic [7:0]            held_data;
        int                    low_cnt;
        int                    high_cnt;
        wr_t                   e;
        prev_we  = '1;
        low_cnt  = 0;
        high_cnt = 100;
        held_addr = '0;
        held_data = '0;
        forever begin
            @(negedge clock);
            if (!notReset) begin
                prev_we  = '1;
                low_cnt  = 0;
                high_cnt = 100;
            end else begin
                check("seq_vs_status", seq_notReset, !busy && !error);
                check("oe_vs_status", rom_notOE, busy || error);
                check("done_error_excl", done & error, 0);
                if (rom_notWE != '1) begin
                    check("one_strobe", $countones(~rom_notWE), 1);
                    check("ready_in_write", in_ready, 0);
                    check("busy_in_write", busy, 1);
                    if (prev_we == '1) begin
                        check("setup_gap", high_cnt >= 2, 1);
                        writes_seen++;
                        held_addr = rom_addr;
                        held_data = rom_data;
                        low_cnt   = 1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL extra_strobe: got lane %0d addr 0x%0h, expected no write at %0t",
                                     lane_of(rom_notWE), rom_addr, $time);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_addr", rom_addr, e.addr);
                            check("wr_lane", lane_of(rom_notWE), e.lane);
                            check("wr_data", rom_data, e.data);
                        end
                    end else begin
                        low_cnt++;
                        check("pulse_stable", {rom_notWE == prev_we, rom_addr == held_addr,
                                               rom_data == held_data}, 3'b111);
                    end
                    high_cnt = 0;
                end else begin
                    if (prev_we != '1) begin
                        check("pulse_len", low_cnt, WE_CYCLES);
                        check("hold_addr", rom_addr, held_addr);
                        check("hold_data", rom_data, held_data);
                    end
                    high_cnt++;
                end
                prev_we = rom_notWE;
            end
        end
    end

    // All driver tasks are entered and left on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("ready_timeout", in_ready, 1);
        if (in_ready) @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic do_load(input int n, input int gap_mode, input bit flip_ck, input int glitch_at);
        logic [15:0] n16;
        logic [7:0]  ck;
        bit          bad;
        bit          exp_ok;
        int          nbytes;
        int          t;
        n16    = 16'(n);
        bad    = (n == 0) || (n > (1 << ADDR_WIDTH));
        nbytes = bad ? 0 : n * WORD_BYTES;
        exp_q.delete();
        writes_seen = 0;
        ck = n16[7:0] ^ n16[15:8];
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back('{addr: ADDR_WIDTH'(i / WORD_BYTES), lane: 8'(i % WORD_BYTES), data: data_q[i]});
            ck = ck ^ data_q[i];
        end
        last_ck = ck;

        pulse_start();
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        exp_ok = 1'b0;
        if (!bad) begin
            for (int i = 0; i < nbytes; i++) begin
                if (i == glitch_at) begin
                    wait_ready();
                    pulse_start();
                    check("start_ignored_busy", busy, 1);
                end
                if (gap_mode == 1 && i == 3) repeat (5) @(negedge clock);
                if (gap_mode == 2) repeat ($urandom_range(0, 3)) @(negedge clock);
                send_byte(data_q[i]);
            end
`ifdef UROM_LOADER_CHECKSUM_EN
            send_byte(flip_ck ? ~ck : ck);
            exp_ok = !flip_ck;
`else
            exp_ok = 1'b1;
`endif
        end

        t = 0;
        while (busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("busy_end", busy, 0);
        check("done_end", done, exp_ok);
        check("error_end", error, !exp_ok);
        check("seq_end", seq_notReset, exp_ok);
        check("oe_end", rom_notOE, !exp_ok);
        check("writes_seen", writes_seen, nbytes);
        check("exp_left", exp_q.size(), 0);
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < n * WORD_BYTES; i++) data_q.push_back(8'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 notReset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_data", rom_data, 0);
        check("rst_rom_notWE", rom_notWE, 6'h3f);
        check("rst_rom_notOE", rom_notOE, 0);
        check("rst_seq_notReset", seq_notReset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        notReset = 1'b1;
        @(negedge clock);

        // N=1, bytes 01..06
        data_q.delete();
        for (int i = 1; i <= 6; i++) data_q.push_back(8'(i));
        do_load(1, 0, 1'b0, -1);
        check("t1_writes", writes_seen, 6);
        check("t1_done", done, 1);
        check("t1_seq", seq_notReset, 1);
        check("t1_model_ck", last_ck, 8'h06);

        // N=2 with a 5-clock host stall mid-word
        fill_random(2);
        do_load(2, 1, 1'b0, -1);

        // Illegal headers
        do_load(0, 0, 1'b0, -1);
        check("t3a_seq", seq_notReset, 0);
        check("t3a_oe", rom_notOE, 1);
        do_load(16'h2001, 0, 1'b0, -1);
        check("t3b_error", error, 1);

        // Reset during a write pulse
        fill_random(1);
        exp_q.delete();
        exp_q.push_back('{addr: '0, lane: 8'd0, data: data_q[0]});
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(data_q[0]);
        begin
            int t;
            t = 0;
            while (rom_notWE == '1 && t < 20) begin
                @(negedge clock);
                t++;
            end
        end
        check("t4_in_pulse", rom_notWE != '1, 1);
        #2 notReset = 1'b0;
        #1;
        check("t4_we_async", rom_notWE, 6'h3f);
        check("t4_busy", busy, 0);
        check("t4_seq", seq_notReset, 1);
        check("t4_oe", rom_notOE, 0);
        @(negedge clock);
        @(negedge clock);
        #1 notReset = 1'b1;
        @(negedge clock);
        exp_q.delete();
        fill_random(2);
        do_load(2, 2, 1'b0, -1);

        // start pulsed during DATA_WAIT
        fill_random(3);
        do_load(3, 0, 1'b0, 4);

        // Randomised loads
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            fill_random(n);
            do_load(n, 2, 1'b0, -1);
        end

`ifdef UROM_LOADER_CHECKSUM_EN
        data_q.delete();
        for (int i = 0; i < 6; i++) data_q.push_back(8'hAA + 8'(i));
        do_load(1, 0, 1'b0, -1);
        check("t6_model_ck", last_ck, 8'h00);
        check("t6_done", done, 1);
        do_load(1, 0, 1'b1, -1);
        check("t6_error", error, 1);
        check("t6_seq", seq_notReset, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
